// File: rtl/nibble_serial_adder_if.sv
// Handshake bundle for nibble_serial_adder.
//   in_valid/in_ready   : operand handshake (a, b, c_in)
//   out_valid/out_ready : result handshake (sum, c_out, ovf)
// Modport slave is the adder side; master is the producer/consumer side.
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf
  );

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Sequential WIDTH-bit adder built around one 4-bit ripple slice. Operands are
// latched on accept, then one nibble (LSB first) is added per clock with the
// carry held in a register between nibbles. The result is presented with a
// valid/ready handshake and held until the consumer takes it.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : nibble_serial_adder_if.slave (operand and result handshakes)
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  nibble_serial_adder_if.slave   bus
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CntW-1:0] KLast = CntW'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  k_q, k_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  // Slice datapath
  logic [CntW+1:0]  bit_idx;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       slice_full;
  logic [3:0]       slice_s;
  logic             slice_c;
  logic             carry_into_msb;

  always_comb begin
    bit_idx        = {k_q, 2'b00};
    a_nib          = a_q[bit_idx +: 4];
    b_nib          = b_q[bit_idx +: 4];
    slice_full     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
    slice_s        = slice_full[3:0];
    slice_c        = slice_full[4];
    // Sum bit = a ^ b ^ carry-in, so carry-in to the top bit falls out directly.
    carry_into_msb = a_nib[3] ^ b_nib[3] ^ slice_s[3];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      k_q     <= k_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    k_d     = k_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          sum_d   = '0;
          k_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[bit_idx +: 4] = slice_s;
        carry_d             = slice_c;
        k_d                 = k_q + 1'b1;
        if (k_q == KLast) begin
          c_out_d = slice_c;
          ovf_d   = carry_into_msb ^ slice_c;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.c_out     = c_out_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;

  localparam int unsigned W   = 16;
  localparam int unsigned NIB = W / 4;

  logic clk;
  logic rst;

  nibble_serial_adder_if #(.WIDTH(W)) bus_if ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic; signed overflow from operand/result signs.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                       output logic [W-1:0] s, output logic co, output logic ov);
    logic [W:0] t;
    t  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    s  = t[W-1:0];
    co = t[W];
    ov = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endtask

  // One full transaction. All driving and sampling happens on negedges.
  task automatic run_op(input logic [W-1:0] a_v, input logic [W-1:0] b_v, input logic cin_v,
                        input int hold, input bit scramble,
                        output logic [W-1:0] s, output logic co, output logic ov);
    int n;
    @(negedge clk);
    check("in_ready before accept", 32'(bus_if.in_ready), 32'd1);
    bus_if.in_valid = 1'b1;
    bus_if.a        = a_v;
    bus_if.b        = b_v;
    bus_if.c_in     = cin_v;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    n = 0;
    while (!bus_if.out_valid && n < 20) begin
      check("in_ready during run", 32'(bus_if.in_ready), 32'd0);
      if (scramble) begin
        bus_if.a        = W'($urandom);
        bus_if.b        = W'($urandom);
        bus_if.c_in     = 1'($urandom);
        bus_if.in_valid = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    bus_if.in_valid = 1'b0;
    check("latency", 32'(n), 32'(NIB));
    s  = bus_if.sum;
    co = bus_if.c_out;
    ov = bus_if.ovf;
    check("in_ready in done", 32'(bus_if.in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus_if.out_ready = 1'b0;
      bus_if.in_valid  = 1'b1;
      bus_if.a         = W'($urandom);
      bus_if.b         = W'($urandom);
      @(negedge clk);
      check("hold out_valid", 32'(bus_if.out_valid), 32'd1);
      check("hold in_ready", 32'(bus_if.in_ready), 32'd0);
      check("hold sum", 32'(bus_if.sum), 32'(s));
      check("hold c_out/ovf", 32'({bus_if.c_out, bus_if.ovf}), 32'({co, ov}));
    end
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    bus_if.out_ready = 1'b0;
    check("out_valid after take", 32'(bus_if.out_valid), 32'd0);
    check("in_ready after take", 32'(bus_if.in_ready), 32'd1);
    check("sum kept in idle", 32'(bus_if.sum), 32'(s));
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  logic [W-1:0] s_got, s_exp;
  logic         co_got, co_exp, ov_got, ov_exp;

  initial begin
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    vecs[7] = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst              = 1'b1;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;
    bus_if.a         = '0;
    bus_if.b         = '0;
    bus_if.c_in      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset in_ready", 32'(bus_if.in_ready), 32'd1);
    check("reset out_valid", 32'(bus_if.out_valid), 32'd0);
    check("reset sum", 32'(bus_if.sum), 32'd0);
    check("reset c_out/ovf", 32'({bus_if.c_out, bus_if.ovf}), 32'd0);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, s_got, co_got, ov_got);
      check($sformatf("vec%0d sum", i), 32'(s_got), 32'(vecs[i].sum));
      check($sformatf("vec%0d c_out", i), 32'(co_got), 32'(vecs[i].cout));
      check($sformatf("vec%0d ovf", i), 32'(ov_got), 32'(vecs[i].ovf));
    end

    // Backpressure with new operands offered in DONE, then a fresh op
    run_op(16'h1234, 16'h4321, 1'b0, 3, 1'b0, s_got, co_got, ov_got);
    check("bp sum", 32'(s_got), 32'h5555);
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0, s_got, co_got, ov_got);
    check("after bp sum", 32'(s_got), 32'h1000);

    // Operands changing during RUN must be ignored
    run_op(16'hABCD, 16'h1111, 1'b1, 0, 1'b1, s_got, co_got, ov_got);
    check("stable sum", 32'(s_got), 32'hBCDF);
    check("stable c_out", 32'(co_got), 32'd0);

    // Reset in the second RUN cycle
    @(negedge clk);
    bus_if.in_valid = 1'b1;
    bus_if.a        = 16'hFFFF;
    bus_if.b        = 16'h0001;
    bus_if.c_in     = 1'b0;
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-rst out_valid", 32'(bus_if.out_valid), 32'd0);
    check("mid-rst in_ready", 32'(bus_if.in_ready), 32'd1);
    check("mid-rst sum", 32'(bus_if.sum), 32'd0);
    check("mid-rst c_out/ovf", 32'({bus_if.c_out, bus_if.ovf}), 32'd0);
    run_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0, s_got, co_got, ov_got);
    check("post-rst sum", 32'(s_got), 32'h0002);
    check("post-rst c_out", 32'(co_got), 32'd0);

    // Reset wins over an accept on the same edge
    @(negedge clk);
    rst             = 1'b1;
    bus_if.in_valid = 1'b1;
    @(negedge clk);
    rst             = 1'b0;
    bus_if.in_valid = 1'b0;
    check("rst priority in_ready", 32'(bus_if.in_ready), 32'd1);
    @(negedge clk);
    check("rst priority no run", 32'(bus_if.in_ready), 32'd1);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if (i % 5 == 0) ra = ~rb;
      model(ra, rb, rc, s_exp, co_exp, ov_exp);
      run_op(ra, rb, rc, int'($urandom_range(0, 2)), 1'($urandom), s_got, co_got, ov_got);
      check("rand sum", 32'(s_got), 32'(s_exp));
      check("rand c_out", 32'(co_got), 32'(co_exp));
      check("rand ovf", 32'(ov_got), 32'(ov_exp));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
